// File: rtl/capture_packer.sv
// capture_packer
// Packs a valid/ack byte stream into 16-bit words for a FIFO write port.
// The first byte of a pair lands in [7:0] and the second in [15:8]. A lone held
// byte is padded out with PAD_BYTE in [15:8] when flush_i is raised or when the
// input has been idle for TIMEOUT cycles. Wrapping word/pad counters are kept
// for debug visibility.
module capture_packer #(
    parameter int         TIMEOUT  = 4096,
    parameter int         W_TO     = 13,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ack_o,
    output logic [15:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    input  logic        flush_i,
    output logic [15:0] stat_words_o,
    output logic [15:0] stat_pads_o
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    // Terminal count of the idle counter. With the timeout disabled the counter
    // simply parks at all-ones and is never used to pad.
    localparam logic [W_TO-1:0] TO_LAST = (TIMEOUT == 0) ? {W_TO{1'b1}}
                                                         : W_TO'(TIMEOUT - 1);

    state_t          state_r;
    logic [7:0]      lo_r;
    logic [W_TO-1:0] to_cnt_r;

    logic            slot_free_s;
    logic            xfer_s;
    logic            ack_s;
    logic            to_expired_s;
    logic            load_word_s;
    logic            load_pad_s;

    // Handshake decode: byte acceptance and which kind of word (if any) loads now.
    always_comb begin
        slot_free_s  = !out_valid_o || out_ready_i;
        xfer_s       = out_valid_o && out_ready_i;
        to_expired_s = (TIMEOUT != 0) && (to_cnt_r == TO_LAST);
        if (state_r == ST_EMPTY) begin
            // Taking the low byte never needs the output slot.
            ack_s       = in_valid_i;
            load_word_s = 1'b0;
            load_pad_s  = 1'b0;
        end else begin
            // Fresh data always wins over a flush or timeout in the same cycle.
            ack_s       = in_valid_i && slot_free_s;
            load_word_s = in_valid_i && slot_free_s;
            load_pad_s  = !in_valid_i && (flush_i || to_expired_s) && slot_free_s;
        end
    end

    assign in_ack_o = ack_s;

    // Packing state and the held low byte.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_EMPTY;
            lo_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_valid_i) begin
                        lo_r    <= in_data_i;
                        state_r <= ST_HALF;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_HALF: begin
                    if (load_word_s || load_pad_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_HALF;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Idle counter: counts HALF cycles without an ack and saturates at the terminal count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            to_cnt_r <= {W_TO{1'b0}};
        end else if ((state_r == ST_EMPTY) || ack_s) begin
            to_cnt_r <= {W_TO{1'b0}};
        end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + W_TO'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Output word register: load a full or padded word, otherwise retire on transfer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_data_o  <= 16'h0000;
            out_valid_o <= 1'b0;
        end else if (load_word_s) begin
            out_data_o  <= {in_data_i, lo_r};
            out_valid_o <= 1'b1;
        end else if (load_pad_s) begin
            out_data_o  <= {PAD_BYTE, lo_r};
            out_valid_o <= 1'b1;
        end else if (xfer_s) begin
            out_valid_o <= 1'b0;
        end else begin
            out_valid_o <= out_valid_o;
        end
    end

    // Debug statistics: words loaded (full and padded) and padded words, both wrapping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_words_o <= 16'h0000;
            stat_pads_o  <= 16'h0000;
        end else begin
            if (load_word_s || load_pad_s) begin
                stat_words_o <= stat_words_o + 16'd1;
            end else begin
                stat_words_o <= stat_words_o;
            end
            if (load_pad_s) begin
                stat_pads_o <= stat_pads_o + 16'd1;
            end else begin
                stat_pads_o <= stat_pads_o;
            end
        end
    end

endmodule
